alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Execute-to-writeback stage sitting directly downstream of the ALU.
- Captures the ALU result and flags plus the destination register and PC into a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Detects signed-overflow traps (ADD/SUB) and illegal ALU opcodes, suppresses the register write, and raises an exception record.
- Locks further intake until the pipeline is flushed.

Parameters:
- DATA_W, 32, width of result/PC datapath.
- REG_W, 5, width of destination register index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_aluc  input  6  ALU opcode of the entry.
- in_r  input  DATA_W  ALU result.
- in_zero, in_carry, in_negative, in_overflow, in_flag  input  1 each  ALU flags.
- in_rd  input  REG_W  destination register.
- in_wen  input  1  instruction writes rd.
- in_pc  input  DATA_W  PC of the instruction.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head.
- out_data  output  DATA_W  write data.
- out_rd  output  REG_W  destination.
- out_wen  output  1  qualified write enable.
- out_zero, out_negative, out_carry  output  1 each  registered flags.
- out_exc  output  1  head entry carries exception.
- out_exc_code  output  2  01 = overflow, 10 = illegal opcode, 00 = none.
- out_epc  output  DATA_W  PC of head entry.

Behaviour:
- Reset: count=0, lock=0, all out_* driven 0, out_valid=0, in_ready=1 in the cycle after reset deasserts.
- Storage: 2-entry circular buffer with rd_ptr, wr_ptr (1 bit each) and count (0..2).
- in_ready = (count!=2) && !lock && !rst; combinational from registers only, never from in_valid or out_ready.
- Push on in_valid&&in_ready; pop on out_valid&&out_ready. out_valid = (count!=0). out_* present the head entry from registers.
- Latency: entry pushed at edge N is visible on out_* in cycle N+1 if the buffer was empty.
- Entry formation at push:
  - SLT (101010) or SLTU (101011): data = zero-extended in_flag.
  - Otherwise: data = in_r.
  - Overflow: aluc ADD (100000) or SUB (100010) with in_overflow=1 -> exc=1, code=01. ADDU/SUBU never trap.
  - Illegal opcode: aluc not in {100000..100111, 101010, 101011, 000000, 000010, 000011, 000100, 000110, 000111, 001111} and in_wen=1 -> exc=1, code=10.
  - Overflow has priority over illegal; these cases are mutually exclusive by encoding.
  - Stored wen = in_wen && (in_rd!=0) && !exc.
- Lock: pushing an entry with exc=1 sets lock=1. No further pushes until flush; already-buffered older entries still drain normally.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances to the new entry in the next cycle.
  - count=2: no push is possible.
  - count=0: pop is impossible.
- Flush: count=0, lock=0, pointers=0, out_valid=0 next cycle. A same-cycle push and pop are both discarded. Flush has priority over push and pop.
- rst has priority over flush.
- Reset or flush mid-operation drops all buffered entries with no partial write.
- out_* are stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then push ADDU with r=0x0000_0005, rd=3, wen=1, out_ready=1 -> out_valid high next cycle, out_data=5, out_rd=3, out_wen=1, out_exc=0.
- Hold out_ready=0, push 3 entries back-to-back (r=1,2,3) -> in_ready drops after the 2nd push. The 3rd entry is held upstream. Releasing out_ready drains 1,2 in order, then 3 is accepted.
- Push ADD with in_overflow=1, pc=0x0040_0010, rd=8 -> out_exc=1, code=01, out_epc=0x0040_0010, out_wen=0, in_ready=0 until flush. After flush, in_ready=1 and out_valid=0.
- Push SLT with in_flag=1, in_r=0xFFFF_FFFF -> out_data=0x0000_0001. Push ADDU with rd=0 and wen=1 -> out_wen=0.
- Push aluc=6'b111111 with wen=1 -> code=10, lock set. Same-cycle flush plus push of a valid entry -> buffer empty, no entry retained.
- count=1 with simultaneous push and pop for 10 cycles (r=k) -> one entry emitted per cycle, in order, count stays 1.

Source files
------------

// File: rtl/alu_result_stage_if.sv
// Handshake and datapath bundle between the ALU result stage, its upstream ALU
// and downstream writeback.
interface alu_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_aluc;
  logic [DATA_W-1:0] in_r;
  logic              in_zero, in_carry, in_negative, in_overflow, in_flag;
  logic [REG_W-1:0]  in_rd;
  logic              in_wen;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_wen;
  logic              out_zero, out_negative, out_carry;
  logic              out_exc;
  logic [1:0]        out_exc_code;
  logic [DATA_W-1:0] out_epc;

  modport slave (
    input  flush, in_valid, in_aluc, in_r, in_zero, in_carry, in_negative,
           in_overflow, in_flag, in_rd, in_wen, in_pc, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_wen, out_zero,
           out_negative, out_carry, out_exc, out_exc_code, out_epc
  );

  modport master (
    output flush, in_valid, in_aluc, in_r, in_zero, in_carry, in_negative,
           in_overflow, in_flag, in_rd, in_wen, in_pc, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_wen, out_zero,
           out_negative, out_carry, out_exc, out_exc_code, out_epc
  );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer that classifies ALU results,
// raises overflow / illegal-opcode exceptions and locks intake until flush.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_result_stage_if.slave bus
);
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [1:0] EXC_OVF = 2'b01;
  localparam logic [1:0] EXC_ILL = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic              zero;
    logic              negative;
    logic              carry;
    logic              exc;
    logic [1:0]        code;
    logic [DATA_W-1:0] epc;
  } entry_t;

  entry_t     mem [2];
  entry_t     nxt, head;
  logic       rd_ptr, wr_ptr, lock;
  logic [1:0] count;
  logic       push, pop, legal, ovf, ill;

  assign bus.in_ready  = (count != 2'd2) && !lock && !rst;
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Entry classification happens once, at intake, so the head is pure registers.
  always_comb begin
    legal = 1'b0;
    unique case (bus.in_aluc)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011, 6'b000000, 6'b000010,
      6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b001111: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
    ovf = bus.in_overflow && (bus.in_aluc == OP_ADD || bus.in_aluc == OP_SUB);
    ill = !legal && bus.in_wen && !ovf;

    nxt          = '0;
    nxt.data     = (bus.in_aluc == OP_SLT || bus.in_aluc == OP_SLTU)
                 ? {{(DATA_W-1){1'b0}}, bus.in_flag} : bus.in_r;
    nxt.rd       = bus.in_rd;
    nxt.zero     = bus.in_zero;
    nxt.negative = bus.in_negative;
    nxt.carry    = bus.in_carry;
    nxt.exc      = ovf || ill;
    nxt.code     = ovf ? EXC_OVF : (ill ? EXC_ILL : 2'b00);
    nxt.wen      = bus.in_wen && (bus.in_rd != '0) && !(ovf || ill);
    nxt.epc      = bus.in_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      lock   <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      lock   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= nxt;
        wr_ptr      <= ~wr_ptr;
        if (nxt.exc) lock <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs read as zero whenever the buffer is empty.
  assign head = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.out_data     = head.data;
  assign bus.out_rd       = head.rd;
  assign bus.out_wen      = head.wen;
  assign bus.out_zero     = head.zero;
  assign bus.out_negative = head.negative;
  assign bus.out_carry    = head.carry;
  assign bus.out_exc      = head.exc;
  assign bus.out_exc_code = head.code;
  assign bus.out_epc      = head.epc;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  alu_result_stage_if #(.DATA_W(32), .REG_W(5)) bus ();
  alu_result_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen, z, n, c, exc;
    logic [1:0]  code;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  bit   m_lock = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    int   op;
    bit   legal, ov, il;
    op    = int'(bus.in_aluc);
    legal = (op >= 32 && op <= 39) || (op inside {42, 43, 0, 2, 3, 4, 6, 7, 15});
    ov    = bus.in_overflow && (op == 32 || op == 34);
    il    = !legal && bus.in_wen;
    e.data = (op == 42 || op == 43) ? {31'b0, bus.in_flag} : bus.in_r;
    e.rd   = bus.in_rd;
    e.z    = bus.in_zero;
    e.n    = bus.in_negative;
    e.c    = bus.in_carry;
    e.exc  = ov || il;
    e.code = ov ? 2'd1 : (il ? 2'd2 : 2'd0);
    e.wen  = bus.in_wen && bus.in_rd != 0 && !e.exc;
    e.epc  = bus.in_pc;
    return e;
  endfunction

  // Reference model: a FIFO of at most two formed entries.
  always @(posedge clk) begin
    bit   m_push, m_pop;
    exp_t e;
    if (rst || bus.flush) begin
      q.delete();
      m_lock = 1'b0;
    end else begin
      m_pop  = (q.size() != 0) && bus.out_ready;
      m_push = bus.in_valid && (q.size() < 2) && !m_lock;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        e = mk();
        q.push_back(e);
        if (e.exc) m_lock = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(!rst && q.size() < 2 && !m_lock));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].data));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
      chk("out_wen", 64'(bus.out_wen), 64'(q[0].wen));
      chk("out_flags", 64'({bus.out_zero, bus.out_negative, bus.out_carry}),
          64'({q[0].z, q[0].n, q[0].c}));
      chk("out_exc", 64'(bus.out_exc), 64'(q[0].exc));
      chk("out_exc_code", 64'(bus.out_exc_code), 64'(q[0].code));
      chk("out_epc", 64'(bus.out_epc), 64'(q[0].epc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] r,
                       input logic [4:0] rd, input bit wen, input logic [31:0] pc,
                       input bit ov, input bit fl);
    bus.in_valid    = v;
    bus.in_aluc     = op;
    bus.in_r        = r;
    bus.in_rd       = rd;
    bus.in_wen      = wen;
    bus.in_pc       = pc;
    bus.in_overflow = ov;
    bus.in_flag     = fl;
    bus.in_zero     = (r == 0);
    bus.in_negative = r[31];
    bus.in_carry    = r[0];
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 6'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_exc", 64'(bus.out_exc), 64'd0);

    // single ADDU, visible next cycle
    bus.out_ready = 1'b1;
    drive(1'b1, 6'b100001, 32'h5, 5'd3, 1'b1, 32'h100, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'd5);
    chk("t1_rd", 64'(bus.out_rd), 64'd3);
    chk("t1_wen", 64'(bus.out_wen), 64'd1);
    chk("t1_exc", 64'(bus.out_exc), 64'd0);
    step();

    // backpressure: third entry held upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b100001, 32'h1, 5'd5, 1'b1, 32'h104, 1'b0, 1'b0);
    step();
    drive(1'b1, 6'b100001, 32'h2, 5'd5, 1'b1, 32'h108, 1'b0, 1'b0);
    step();
    chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 6'b100001, 32'h3, 5'd5, 1'b1, 32'h10c, 1'b0, 1'b0);
    step(); step();
    chk("t2_hold_data", 64'(bus.out_data), 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("t2_drain1", 64'(bus.out_data), 64'd2);
    step();
    chk("t2_drain2", 64'(bus.out_data), 64'd3);
    bus.in_valid = 1'b0;
    step();
    chk("t2_empty", 64'(bus.out_valid), 64'd0);

    // ADD overflow trap, lock until flush
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b100000, 32'h8000_0000, 5'd8, 1'b1, 32'h0040_0010, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("t3_exc", 64'(bus.out_exc), 64'd1);
    chk("t3_code", 64'(bus.out_exc_code), 64'd1);
    chk("t3_epc", 64'(bus.out_epc), 64'h0040_0010);
    chk("t3_wen", 64'(bus.out_wen), 64'd0);
    chk("t3_lock", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step(); step();
    chk("t3_lock_held", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t3_flush_ready", 64'(bus.in_ready), 64'd1);
    chk("t3_flush_valid", 64'(bus.out_valid), 64'd0);

    // SUBU overflow never traps; SUB does
    drive(1'b1, 6'b100011, 32'h7fff_ffff, 5'd9, 1'b1, 32'h200, 1'b1, 1'b0);
    step();
    chk("subu_exc", 64'(bus.out_exc), 64'd0);
    chk("subu_wen", 64'(bus.out_wen), 64'd1);
    drive(1'b1, 6'b100010, 32'h7fff_ffff, 5'd9, 1'b1, 32'h204, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("sub_code", 64'(bus.out_exc_code), 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;

    // SLT zero-extends the flag; rd=0 suppresses write
    drive(1'b1, 6'b101010, 32'hffff_ffff, 5'd4, 1'b1, 32'h300, 1'b0, 1'b1);
    step();
    chk("slt_data", 64'(bus.out_data), 64'd1);
    drive(1'b1, 6'b100001, 32'h55, 5'd0, 1'b1, 32'h304, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("rd0_wen", 64'(bus.out_wen), 64'd0);
    step();

    // illegal opcode without wen is harmless
    drive(1'b1, 6'b111111, 32'h9, 5'd2, 1'b0, 32'h400, 1'b0, 1'b0);
    step();
    chk("ill_nowen_exc", 64'(bus.out_exc), 64'd0);
    bus.in_valid = 1'b0;
    step();

    // illegal opcode with wen locks; flush beats a same-cycle push
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b111111, 32'h9, 5'd2, 1'b1, 32'h500, 1'b0, 1'b0);
    step();
    chk("ill_code", 64'(bus.out_exc_code), 64'd2);
    chk("ill_lock", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 6'b100001, 32'h77, 5'd6, 1'b1, 32'h504, 1'b0, 1'b0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_push_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("flush_push_stay", 64'(bus.out_valid), 64'd0);

    // reset mid-operation drops buffered entries
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b100100, 32'hab, 5'd7, 1'b1, 32'h600, 1'b0, 1'b0);
    step(); step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);

    // streaming at count=1: one entry out per cycle
    bus.out_ready = 1'b1;
    drive(1'b1, 6'b100001, 32'd100, 5'd1, 1'b1, 32'h700, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 6'b100001, 32'(k), 5'd1, 1'b1, 32'h704 + 32'(4 * k), 1'b0, 1'b0);
      step();
      chk("stream_data", 64'(bus.out_data), 64'(k));
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
